vga_dither_out: RTL and testbench

VGA_DITHER_OUT -- requirements
Module: vga_dither_out

---
 rtl/vga_dither_pkg.sv | 16 +
 rtl/vga_dither_channel.sv | 25 ++
 rtl/vga_dither_out.sv | 74 +++++++
 tb/tb_vga_dither_out.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vga_dither_pkg.sv
// vga_dither_pkg: shared widths and the 4x4 Bayer matrix for the VGA dither output stage
package vga_dither_pkg;
   localparam int IN_W  = 6;
   localparam int OUT_W = 3;
   localparam int CNT_W = 2;
   localparam logic [3:0] BAYER [4][4] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6},
      '{4'd3,  4'd11, 4'd1,  4'd9},
      '{4'd15, 4'd7,  4'd13, 4'd5}
   };
   // Halved Bayer entry (0..7), compared against the 3 dropped low bits.
   function automatic logic [OUT_W-1:0] bayer_thresh(input logic [CNT_W-1:0] x, input logic [CNT_W-1:0] y);
      return BAYER[y][x][3:1];
   endfunction
endpackage

// File: rtl/vga_dither_channel.sv
// dither_channel: one colour channel, 6-bit in -> 3-bit ordered-dither or truncated, registered
//   clk_vga, rst_n : pixel clock, async active-low reset
//   pix            : 6-bit colour, x/y : Bayer index, en : 1 = dither, 0 = truncate
//   q              : 3-bit registered output
module dither_channel import vga_dither_pkg::*; (
   input  logic             clk_vga,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  pix,
   input  logic [CNT_W-1:0] x,
   input  logic [CNT_W-1:0] y,
   input  logic             en,
   output logic [OUT_W-1:0] q
);
   logic [OUT_W-1:0] hi, lo, t;
   logic [OUT_W:0]   sum;
   always_comb begin
      hi  = pix[IN_W-1 -: OUT_W];
      lo  = pix[OUT_W-1:0];
      t   = bayer_thresh(x, y);
      sum = {1'b0, hi} + {{OUT_W{1'b0}}, lo > t};
   end
   always_ff @(posedge clk_vga or negedge rst_n)
      if (!rst_n) q <= '0;
      else        q <= !en ? hi : sum[OUT_W] ? '1 : sum[OUT_W-1:0];
endmodule

// File: rtl/vga_dither_out.sv
// vga_dither_out: 18-bit pixel to 9-bit VGA DAC with ordered dither, 2-cycle latency on colour and syncs
//   clk_vga, rst_n           : pixel clock, async active-low reset
//   dither_en                : 1 = ordered dither, 0 = plain truncation
//   r_in, g_in, b_in         : 6-bit colour; hsync_in, vsync_in : syncs aligned with colour
//   vga_r, vga_g, vga_b      : 3-bit colour to DAC; vga_hsync, vga_vsync : syncs aligned with colour
module vga_dither_out import vga_dither_pkg::*; #(
   parameter bit HSYNC_POL = 1'b0,
   parameter bit VSYNC_POL = 1'b0,
   parameter bit TEMPORAL  = 1'b1
) (
   input  logic             clk_vga,
   input  logic             rst_n,
   input  logic             dither_en,
   input  logic [IN_W-1:0]  r_in,
   input  logic [IN_W-1:0]  g_in,
   input  logic [IN_W-1:0]  b_in,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [OUT_W-1:0] vga_r,
   output logic [OUT_W-1:0] vga_g,
   output logic [OUT_W-1:0] vga_b,
   output logic             vga_hsync,
   output logic             vga_vsync
);
   logic [CNT_W-1:0] cx, cy, fc, px, py, x1, y1;
   logic [IN_W-1:0]  r1, g1, b1;
   logic             hs_prev, vs_prev, armed, hs_edge, vs_edge, en1, hs1, vs1;
   // armed stays low for the first cycle after reset so a sync already active at release is not an edge
   always_comb begin
      hs_edge = armed && (hsync_in == HSYNC_POL) && (hs_prev != HSYNC_POL);
      vs_edge = armed && (vsync_in == VSYNC_POL) && (vs_prev != VSYNC_POL);
      px      = TEMPORAL ? cx ^ {CNT_W{fc[0]}} : cx;
      py      = TEMPORAL ? cy ^ {CNT_W{fc[1]}} : cy;
   end
   always_ff @(posedge clk_vga or negedge rst_n)
      if (!rst_n) begin
         cx        <= '0;
         cy        <= '0;
         fc        <= '0;
         armed     <= 1'b0;
         hs_prev   <= ~HSYNC_POL;
         vs_prev   <= ~VSYNC_POL;
         r1        <= '0;
         g1        <= '0;
         b1        <= '0;
         en1       <= 1'b0;
         x1        <= '0;
         y1        <= '0;
         hs1       <= ~HSYNC_POL;
         vs1       <= ~VSYNC_POL;
         vga_hsync <= ~HSYNC_POL;
         vga_vsync <= ~VSYNC_POL;
      end else begin
         armed     <= 1'b1;
         hs_prev   <= hsync_in;
         vs_prev   <= vsync_in;
         cx        <= hs_edge ? '0 : cx + CNT_W'(1);
         cy        <= vs_edge ? '0 : hs_edge ? cy + CNT_W'(1) : cy;
         fc        <= vs_edge ? fc + CNT_W'(1) : fc;
         r1        <= r_in;
         g1        <= g_in;
         b1        <= b_in;
         en1       <= dither_en;
         x1        <= px;
         y1        <= py;
         hs1       <= hsync_in;
         vs1       <= vsync_in;
         vga_hsync <= hs1;
         vga_vsync <= vs1;
      end
   dither_channel u_r (.clk_vga(clk_vga), .rst_n(rst_n), .pix(r1), .x(x1), .y(y1), .en(en1), .q(vga_r));
   dither_channel u_g (.clk_vga(clk_vga), .rst_n(rst_n), .pix(g1), .x(x1), .y(y1), .en(en1), .q(vga_g));
   dither_channel u_b (.clk_vga(clk_vga), .rst_n(rst_n), .pix(b1), .x(x1), .y(y1), .en(en1), .q(vga_b));
endmodule

// File: tb/tb_vga_dither_out.sv
// tb_vga_dither_out: randomized check of vga_dither_out (temporal and static instances) against a behavioural model
module tb_vga_dither_out;
   logic       clk_vga = 1'b0, rst_n = 1'b0, dither_en = 1'b0;
   logic [5:0] r_in = '0, g_in = '0, b_in = '0;
   logic       hsync_in = 1'b1, vsync_in = 1'b1;
   logic [2:0] t_r, t_g, t_b, s_r, s_g, s_b;
   logic       t_hs, t_vs, s_hs, s_vs;
   int pass_cnt = 0, total = 0;
   int bay [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
   int cx, cy, fc, hs_prev, vs_prev, first;
   int p1 [6], p2 [6];
   int sh1, sv1, sh2, sv2;

   vga_dither_out dut_t (
      .clk_vga(clk_vga), .rst_n(rst_n), .dither_en(dither_en),
      .r_in(r_in), .g_in(g_in), .b_in(b_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .vga_r(t_r), .vga_g(t_g), .vga_b(t_b), .vga_hsync(t_hs), .vga_vsync(t_vs));
   vga_dither_out #(.TEMPORAL(1'b0)) dut_s (
      .clk_vga(clk_vga), .rst_n(rst_n), .dither_en(dither_en),
      .r_in(r_in), .g_in(g_in), .b_in(b_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .vga_r(s_r), .vga_g(s_g), .vga_b(s_b), .vga_hsync(s_hs), .vga_vsync(s_vs));

   always #5 clk_vga = ~clk_vga;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
   endtask

   function automatic int dith(input int v, input int en, input int x, input int y);
      int r;
      if (en == 0) return v / 8;
      r = v / 8 + (((v % 8) > (bay[y][x] / 2)) ? 1 : 0);
      return r > 7 ? 7 : r;
   endfunction

   task automatic model_reset();
      cx = 0; cy = 0; fc = 0; hs_prev = 1; vs_prev = 1; first = 1;
      for (int i = 0; i < 6; i++) begin p1[i] = 0; p2[i] = 0; end
      sh1 = 1; sv1 = 1; sh2 = 1; sv2 = 1;
   endtask

   task automatic model_step();
      int tx, ty, hs_e, vs_e, en;
      en = int'(dither_en);
      tx = cx ^ ((fc % 2) != 0 ? 3 : 0);
      ty = cy ^ ((fc / 2) != 0 ? 3 : 0);
      p2 = p1; sh2 = sh1; sv2 = sv1;
      p1[0] = dith(int'(r_in), en, tx, ty);
      p1[1] = dith(int'(g_in), en, tx, ty);
      p1[2] = dith(int'(b_in), en, tx, ty);
      p1[3] = dith(int'(r_in), en, cx, cy);
      p1[4] = dith(int'(g_in), en, cx, cy);
      p1[5] = dith(int'(b_in), en, cx, cy);
      sh1 = int'(hsync_in); sv1 = int'(vsync_in);
      hs_e = (first == 0 && hsync_in == 1'b0 && hs_prev == 1) ? 1 : 0;
      vs_e = (first == 0 && vsync_in == 1'b0 && vs_prev == 1) ? 1 : 0;
      cx = hs_e != 0 ? 0 : (cx + 1) % 4;
      cy = vs_e != 0 ? 0 : hs_e != 0 ? (cy + 1) % 4 : cy;
      fc = vs_e != 0 ? (fc + 1) % 4 : fc;
      hs_prev = int'(hsync_in); vs_prev = int'(vsync_in); first = 0;
   endtask

   task automatic compare();
      check("t_r", t_r, p2[0]); check("t_g", t_g, p2[1]); check("t_b", t_b, p2[2]);
      check("s_r", s_r, p2[3]); check("s_g", s_g, p2[4]); check("s_b", s_b, p2[5]);
      check("t_hs", t_hs, sh2); check("t_vs", t_vs, sv2);
      check("s_hs", s_hs, sh2); check("s_vs", s_vs, sv2);
   endtask

   task automatic tick();
      @(posedge clk_vga);
      if (rst_n) model_step(); else model_reset();
      @(negedge clk_vga);
      compare();
   endtask

   task automatic pix(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b, input logic en, input logic hs, input logic vs);
      r_in = r; g_in = g; b_in = b; dither_en = en; hsync_in = hs; vsync_in = vs;
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_async_r", t_r, 0); check("rst_async_g", s_g, 0);
      check("rst_async_hs", t_hs, 1); check("rst_async_vs", s_vs, 1);
      model_reset();
      @(negedge clk_vga);
      tick(); tick();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      hsync_in = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      // truncation of 6'h2D over every column
      for (int i = 0; i < 8; i++) begin
         pix(6'h2D, 6'h2D, 6'h2D, 1'b0, 1'b1, 1'b1);
         tick();
      end
      check("trunc_2d_t", t_r, 5); check("trunc_2d_s", s_r, 5);
      // flat 6'h0C, frames started by coincident hsync/vsync edges
      for (int f = 0; f < 5; f++) begin
         pix(6'h0C, 6'h0C, 6'h0C, 1'b1, 1'b0, 1'b0);
         tick();
         for (int l = 0; l < 4; l++) begin
            for (int p = 0; p < 4; p++) begin
               pix(6'h0C, 6'h0C, 6'h0C, 1'b1, 1'b1, 1'b1);
               tick();
            end
            pix(6'h0C, 6'h0C, 6'h0C, 1'b1, 1'b0, 1'b1);
            tick();
         end
      end
      // extremes saturate/clear in both modes
      for (int i = 0; i < 40; i++) begin
         pix(6'h3F, 6'h00, 6'h3F, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 15) != 0));
         tick();
         if (i >= 2) begin
            check("sat_t_r", t_r, 7); check("sat_s_b", s_b, 7); check("zero_t_g", t_g, 0);
         end
      end
      // random traffic with a mid-line reset
      for (int i = 0; i < 2000; i++) begin
         if (i == 700 || i == 1400) mid_reset();
         pix(6'($urandom), 6'($urandom), 6'($urandom),
             ($urandom_range(0, 15) == 0) ? ~dither_en : dither_en,
             ($urandom_range(0, 9) != 0), ($urandom_range(0, 49) != 0));
         tick();
      end
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
